// File: rtl/ras_checkpointed_if.sv
// Fetch-side interface of the checkpointed return address stack.
// The fetch unit is the master; the stack itself is the slave.
interface ras_checkpointed_if #(
    parameter int ADDR_W = 32
) ();
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] new_addr;
    logic              branch_fetched;
    logic              branch_retired;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic              empty;
    logic              ckpt_full;

    modport master (
        output push, pop, new_addr, branch_fetched, branch_retired, flush,
        input  addr, empty, ckpt_full
    );

    modport slave (
        input  push, pop, new_addr, branch_fetched, branch_retired, flush,
        output addr, empty, ckpt_full
    );
endinterface

// File: rtl/ras_checkpointed.sv
// Circular return address stack with a checkpoint queue of {top,count} per fetched branch.
// A flush rolls top/count back to the state captured by the last retired branch.
module ras_checkpointed #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ras_checkpointed_if.slave       bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int QPTR_W = $clog2(MAX_INFLIGHT);
    localparam int QCNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_committed_top;
    logic [CNT_W-1:0]  r_committed_count;

    logic [PTR_W-1:0]  r_q_top   [MAX_INFLIGHT];
    logic [CNT_W-1:0]  r_q_count [MAX_INFLIGHT];
    logic [QPTR_W-1:0] r_q_head;
    logic [QPTR_W-1:0] r_q_tail;
    logic [QCNT_W-1:0] r_q_occ;

    logic [PTR_W-1:0]  w_top;
    logic [CNT_W-1:0]  w_count;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_q_full;
    logic              w_enq;
    logic              w_deq;

    assign w_q_full = (r_q_occ == QCNT_W'(MAX_INFLIGHT));
    assign w_deq    = bus.branch_retired && (r_q_occ != '0);
    // A full queue still accepts a new branch when the oldest one retires in the same cycle.
    assign w_enq    = bus.branch_fetched && (!w_q_full || w_deq);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_top    = r_top;
        w_count  = r_count;
        w_wr_en  = 1'b0;
        w_wr_idx = r_top;
        if (bus.push && !bus.pop) begin
            w_top    = r_top + PTR_W'(1);
            w_count  = (r_count == CNT_W'(DEPTH)) ? r_count : r_count + CNT_W'(1);
            w_wr_en  = 1'b1;
            w_wr_idx = r_top + PTR_W'(1);
        end else if (bus.pop && !bus.push) begin
            w_top    = r_top - PTR_W'(1);
            w_count  = (r_count == '0) ? r_count : r_count - CNT_W'(1);
        end else if (bus.push && bus.pop) begin
            w_wr_en  = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stack array is reset too, so addr reads 0 until something is pushed.
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                r_q_top[i]   <= '0;
                r_q_count[i] <= '0;
            end
            r_top             <= '0;
            r_count           <= '0;
            r_committed_top   <= '0;
            r_committed_count <= '0;
            r_q_head          <= '0;
            r_q_tail          <= '0;
            r_q_occ           <= '0;
        end else if (bus.flush) begin
            // Stack contents are left alone; squashed pushes are only a prediction loss.
            r_top    <= r_committed_top;
            r_count  <= r_committed_count;
            r_q_head <= '0;
            r_q_tail <= '0;
            r_q_occ  <= '0;
        end else begin
            if (w_wr_en) r_stack[w_wr_idx] <= bus.new_addr;
            r_top   <= w_top;
            r_count <= w_count;
            if (w_enq) begin
                r_q_top[r_q_tail]   <= w_top;
                r_q_count[r_q_tail] <= w_count;
                r_q_tail            <= r_q_tail + QPTR_W'(1);
            end
            if (w_deq) begin
                r_committed_top   <= r_q_top[r_q_head];
                r_committed_count <= r_q_count[r_q_head];
                r_q_head          <= r_q_head + QPTR_W'(1);
            end
            r_q_occ <= r_q_occ + QCNT_W'(w_enq) - QCNT_W'(w_deq);
        end
    end

    assign bus.addr      = r_stack[r_top];
    assign bus.empty     = (r_count == '0);
    assign bus.ckpt_full = w_q_full;
endmodule

// File: tb/tb_ras_checkpointed.sv
// Directed-vector bench for ras_checkpointed (DEPTH=8, ADDR_W=32, MAX_INFLIGHT=4).
// Each vector drives one cycle of inputs and names the outputs expected after that edge.
module tb_ras_checkpointed;
    typedef struct {
        string       name;
        logic        rst;
        logic        push;
        logic        pop;
        logic [31:0] new_addr;
        logic        fetched;
        logic        retired;
        logic        flush;
        logic [31:0] exp_addr;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    ras_checkpointed_if #(.ADDR_W(32)) bus ();

    ras_checkpointed #(
        .DEPTH        (8),
        .ADDR_W       (32),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic r, input logic pu, input logic po,
                                input logic [31:0] a, input logic bf, input logic br,
                                input logic fl, input logic [31:0] ea, input logic ee,
                                input logic ef);
        vec_t v;
        v = '{n, r, pu, po, a, bf, br, fl, ea, ee, ef};
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        rst                = v.rst;
        bus.push           = v.push;
        bus.pop            = v.pop;
        bus.new_addr       = v.new_addr;
        bus.branch_fetched = v.fetched;
        bus.branch_retired = v.retired;
        bus.flush          = v.flush;
        @(posedge clk);
        #1;
        check({v.name, " addr"},  bus.addr,             v.exp_addr);
        check({v.name, " empty"}, 32'(bus.empty),       32'(v.exp_empty));
        check({v.name, " full"},  32'(bus.ckpt_full),   32'(v.exp_full));
    endtask

    initial begin
        bus.push = 0; bus.pop = 0; bus.new_addr = '0;
        bus.branch_fetched = 0; bus.branch_retired = 0; bus.flush = 0;

        //   name          rst pu po addr    bf br fl exp_addr exp_e exp_f
        add("reset",       1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        add("t1 push A",   0, 1, 0, 32'h100, 0, 0, 0, 32'h100, 0, 0);
        add("t1 push B",   0, 1, 0, 32'h200, 0, 0, 0, 32'h200, 0, 0);
        add("t1 push C",   0, 1, 0, 32'h300, 0, 0, 0, 32'h300, 0, 0);
        add("t1 pop 1",    0, 0, 1, 32'h0,   0, 0, 0, 32'h200, 0, 0);
        add("t1 pop 2",    0, 0, 1, 32'h0,   0, 0, 0, 32'h100, 0, 0);
        add("t1 pop 3",    0, 0, 1, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        add("t2 reset",    1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        // Nine calls into an 8-deep stack: the ninth overwrites slot 1 (held 0x10).
        for (int k = 1; k <= 9; k++)
            add($sformatf("t2 push %0d", k), 0, 1, 0, 32'(k * 16), 0, 0, 0, 32'(k * 16), 0, 0);
        // Pops walk 0x80..0x20; the eighth empties the stack and leaves stale 0x90 on top.
        for (int j = 1; j <= 8; j++)
            add($sformatf("t2 pop %0d", j), 0, 0, 1, 32'h0, 0, 0, 0,
                (j < 8) ? 32'(144 - 16 * j) : 32'h90, (j == 8), 0);
        add("t3 reset",    1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        add("t3 push",     0, 1, 0, 32'h40,  0, 0, 0, 32'h40,  0, 0);
        add("t3 push&pop", 0, 1, 1, 32'h44,  0, 0, 0, 32'h44,  0, 0);
        add("t3 pop",      0, 0, 1, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        add("t4 reset",    1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0);
        add("t4 push+bf",  0, 1, 0, 32'h500, 1, 0, 0, 32'h500, 0, 0);
        add("t4 retire",   0, 0, 0, 32'h0,   0, 1, 0, 32'h500, 0, 0);
        add("t4 push+bf2", 0, 1, 0, 32'h600, 1, 0, 0, 32'h600, 0, 0);
        add("t4 flush",    0, 0, 0, 32'h0,   0, 0, 1, 32'h500, 0, 0);
        add("t4 pop",      0, 0, 1, 32'h0,   0, 0, 0, 32'h0,   1, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Checkpoint queue fill, dropped fetch on full, simultaneous retire+fetch on full.
        begin
            vec_t v;
            v = '{"t5 bf", 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0};
            for (int k = 1; k <= 3; k++) begin
                v.name = $sformatf("t5 bf %0d", k);
                apply(v);
            end
            v.name = "t5 bf 4";     v.exp_full = 1; apply(v);
            v.name = "t5 bf 5 drop";                apply(v);
            v.name = "t5 bf+retire"; v.retired = 1; apply(v);
            v.name = "t5 retire";   v.fetched = 0;  v.exp_full = 0; apply(v);
            v.name = "t5 refill";   v.fetched = 1;  v.retired = 0; v.exp_full = 1; apply(v);
            v.name = "t5 flush";    v.fetched = 0;  v.flush = 1;   v.exp_full = 0; apply(v);
        end

        // Flush beats a same-cycle push; reset beats everything mid-sequence.
        begin
            vec_t v;
            v = '{"t6 push+bf", 0, 1, 0, 32'h650, 1, 0, 0, 32'h650, 0, 0};  apply(v);
            v = '{"t6 retire",  0, 0, 0, 32'h0,   0, 1, 0, 32'h650, 0, 0};  apply(v);
            v = '{"t6 push",    0, 1, 0, 32'h700, 0, 0, 0, 32'h700, 0, 0};  apply(v);
            v = '{"t6 flush+push", 0, 1, 0, 32'h800, 1, 1, 1, 32'h650, 0, 0}; apply(v);
            v = '{"t6 pop",     0, 0, 1, 32'h0,   0, 0, 0, 32'h0,   1, 0};  apply(v);
            v = '{"t6 push2",   0, 1, 0, 32'h900, 1, 0, 0, 32'h900, 0, 0};  apply(v);
            v = '{"t6 rst+push", 1, 1, 0, 32'hA00, 1, 0, 0, 32'h0,  1, 0};  apply(v);
            v = '{"t6 idle",    0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0};  apply(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
